// File: rtl/video_pkg.sv
// Shared video-timing constants and types for the capture-side pixel pipeline.
// Geometry helpers pick the active window from the line_doubler mode bit.
package video_pkg;

  localparam logic [11:0] WIDTH_480P  = 12'd720;
  localparam logic [11:0] HEIGHT_480P = 12'd480;
  localparam logic [11:0] WIDTH_240P  = 12'd640;
  localparam logic [11:0] HEIGHT_240P = 12'd240;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LINE = 2'd1;
  localparam state_t GAP  = 2'd2;
  localparam state_t DONE = 2'd3;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  function automatic logic [11:0] widthFor(input logic lineDoubler);
    return lineDoubler ? WIDTH_240P : WIDTH_480P;
  endfunction

  function automatic logic [11:0] heightFor(input logic lineDoubler);
    return lineDoubler ? HEIGHT_240P : HEIGHT_480P;
  endfunction

endpackage

// File: rtl/line_buffer_writer.sv
// Writes visible pixels of the captured stream into a slotted line-buffer RAM and
// tells the read side when enough lines of the current frame are buffered.
module line_buffer_writer
  import video_pkg::*;
#(
  parameter int SLOT_BITS  = 2,
  parameter int X_BITS     = 10,
  parameter int LEAD_LINES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        line_doubler,
  input  logic                        add_line,
  input  logic [11:0]                 counterX,
  input  logic [11:0]                 counterY,
  input  logic [7:0]                  red,
  input  logic [7:0]                  green,
  input  logic [7:0]                  blue,
  output logic [SLOT_BITS+X_BITS-1:0] wraddress,
  output logic [23:0]                 wrdata,
  output logic                        wren,
  output logic                        line_done,
  output logic                        frame_start,
  output logic                        starttrigger,
  output logic                        add_line_out
);

  state_t                        state_q, state_d;
  logic [SLOT_BITS-1:0]          slot_q, slot_d;
  logic [7:0]                    lineCount_q, lineCount_d;
  logic                          lineDoubler_q, lineDoubler_d;
  logic                          addLineOut_q, addLineOut_d;
  logic                          wren_q, wren_d;
  logic [SLOT_BITS+X_BITS-1:0]   wraddress_q, wraddress_d;
  logic [23:0]                   wrdata_q, wrdata_d;
  logic                          lineDone_q, lineDone_d;
  logic                          frameStart_q, frameStart_d;
  logic                          startTrig_q, startTrig_d;

  rgb888_t     pixel;
  logic [11:0] frameWidth;
  logic [11:0] frameHeight;
  logic        isOrigin;
  logic        isVisible;

  assign pixel       = '{red: red, green: green, blue: blue};
  assign frameWidth  = widthFor(lineDoubler_q);
  assign frameHeight = heightFor(lineDoubler_q);
  assign isOrigin    = (counterX == 12'd0) && (counterY == 12'd0);
  assign isVisible   = (counterX < frameWidth) && (counterY < frameHeight);

  // A frame origin always wins, whatever state we are in, so a sync glitch restarts cleanly.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    lineCount_d   = lineCount_q;
    lineDoubler_d = lineDoubler_q;
    addLineOut_d  = addLineOut_q;
    wren_d        = 1'b0;
    wraddress_d   = wraddress_q;
    wrdata_d      = wrdata_q;
    lineDone_d    = 1'b0;
    frameStart_d  = 1'b0;
    startTrig_d   = startTrig_q | (lineCount_q >= 8'(LEAD_LINES));

    if (isOrigin) begin
      frameStart_d  = 1'b1;
      lineDoubler_d = line_doubler;
      addLineOut_d  = add_line;
      slot_d        = '0;
      lineCount_d   = '0;
      startTrig_d   = 1'b0;
      state_d       = LINE;
      wren_d        = 1'b1;
      wraddress_d   = '0;
      wrdata_d      = pixel;
    end else begin
      case (state_q)
        LINE: begin
          if (isVisible) begin
            wren_d      = 1'b1;
            wraddress_d = {slot_q, counterX[X_BITS-1:0]};
            wrdata_d    = pixel;
            if (counterX == frameWidth - 12'd1) begin
              lineDone_d  = 1'b1;
              slot_d      = slot_q + SLOT_BITS'(1);
              lineCount_d = (lineCount_q == 8'hFF) ? lineCount_q : lineCount_q + 8'd1;
              state_d     = (counterY == frameHeight - 12'd1) ? DONE : GAP;
            end
          end
        end
        GAP: begin
          if (counterX == 12'd0 && counterY < frameHeight) begin
            state_d     = LINE;
            wren_d      = 1'b1;
            wraddress_d = {slot_q, counterX[X_BITS-1:0]};
            wrdata_d    = pixel;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      lineCount_q   <= '0;
      lineDoubler_q <= 1'b0;
      addLineOut_q  <= 1'b0;
      wren_q        <= 1'b0;
      wraddress_q   <= '0;
      wrdata_q      <= '0;
      lineDone_q    <= 1'b0;
      frameStart_q  <= 1'b0;
      startTrig_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      lineCount_q   <= lineCount_d;
      lineDoubler_q <= lineDoubler_d;
      addLineOut_q  <= addLineOut_d;
      wren_q        <= wren_d;
      wraddress_q   <= wraddress_d;
      wrdata_q      <= wrdata_d;
      lineDone_q    <= lineDone_d;
      frameStart_q  <= frameStart_d;
      startTrig_q   <= startTrig_d;
    end
  end

  assign wraddress    = wraddress_q;
  assign wrdata       = wrdata_q;
  assign wren         = wren_q;
  assign line_done    = lineDone_q;
  assign frame_start  = frameStart_q;
  assign starttrigger = startTrig_q;
  assign add_line_out = addLineOut_q;

endmodule

// File: tb/tb_line_buffer_writer.sv
// Directed bench for line_buffer_writer: a frame-level reference model queues the
// expected RAM writes per pixel, and every cycle's outputs are checked against it.
module tb_line_buffer_writer;

  localparam int SLOT_BITS  = 2;
  localparam int X_BITS     = 10;
  localparam int LEAD_LINES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        line_doubler = 1'b0;
  logic        add_line = 1'b0;
  logic [11:0] counterX = '0;
  logic [11:0] counterY = '0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic [SLOT_BITS+X_BITS-1:0] wraddress;
  logic [23:0] wrdata;
  logic        wren, line_done, frame_start, starttrigger, add_line_out;

  line_buffer_writer #(.SLOT_BITS(SLOT_BITS), .X_BITS(X_BITS), .LEAD_LINES(LEAD_LINES)) dut (
    .clock(clock), .reset(reset), .line_doubler(line_doubler), .add_line(add_line),
    .counterX(counterX), .counterY(counterY), .red(red), .green(green), .blue(blue),
    .wraddress(wraddress), .wrdata(wrdata), .wren(wren), .line_done(line_done),
    .frame_start(frame_start), .starttrigger(starttrigger), .add_line_out(add_line_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
  } write_t;

  write_t expQ[$];
  int     testsRun = 0;
  int     testsFailed = 0;
  int     obsWrites = 0;
  int     obsLineDone = 0;

  bit mFrame = 0, mLineOpen = 0, mTrig = 0, mAddOut = 0;
  int mW = 720, mH = 480, mSlot = 0, mLines = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pixelFor(input int x, input int y);
    logic [7:0] a, b;
    a = x[7:0];
    b = y[7:0];
    return {a, b, a ^ b};
  endfunction

  task automatic modelReset();
    mFrame = 0; mLineOpen = 0; mTrig = 0; mAddOut = 0; mSlot = 0; mLines = 0;
    expQ.delete();
  endtask

  // One pixel per call: update the frame model, clock it in, then check outputs one cycle later.
  task automatic applyStimulus(input int x, input int y, input logic [23:0] rgb);
    write_t w;
    bit     expFs, expLd;
    counterX = x[11:0];
    counterY = y[11:0];
    {red, green, blue} = rgb;
    expFs = 0;
    expLd = 0;
    if (x == 0 && y == 0) begin
      mTrig = 0;
      mW = line_doubler ? 640 : 720;
      mH = line_doubler ? 240 : 480;
      mAddOut = add_line;
      mSlot = 0; mLines = 0; mFrame = 1; mLineOpen = 1;
      expFs = 1;
      w.addr = '0; w.data = rgb;
      expQ.push_back(w);
    end else begin
      mTrig = mTrig || (mLines >= LEAD_LINES);
      if (mFrame) begin
        if (!mLineOpen && x == 0 && y < mH) mLineOpen = 1;
        if (mLineOpen && x < mW && y < mH) begin
          w.addr = 12'((mSlot << X_BITS) + x);
          w.data = rgb;
          expQ.push_back(w);
          if (x == mW - 1) begin
            expLd = 1;
            mSlot = (mSlot + 1) % (1 << SLOT_BITS);
            mLines = (mLines < 255) ? mLines + 1 : 255;
            mLineOpen = 0;
            if (y == mH - 1) mFrame = 0;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    if (wren) obsWrites++;
    if (line_done) obsLineDone++;
    if (expQ.size() > 0) begin
      w = expQ.pop_front();
      checkOutput("wren", 32'(wren), 32'd1);
      checkOutput("wraddress", 32'(wraddress), 32'(w.addr));
      checkOutput("wrdata", 32'(wrdata), 32'(w.data));
    end else begin
      checkOutput("wren_idle", 32'(wren), 32'd0);
    end
    checkOutput("line_done", 32'(line_done), 32'(expLd));
    checkOutput("frame_start", 32'(frame_start), 32'(expFs));
    checkOutput("starttrigger", 32'(starttrigger), 32'(mTrig));
    checkOutput("add_line_out", 32'(add_line_out), 32'(mAddOut));
  endtask

  task automatic runLine(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) applyStimulus(x, y, pixelFor(x, y));
  endtask

  initial begin
    int ys480[$];
    int ys240[$];
    ys480 = '{2, 3, 4, 477, 478, 479, 480, 500};
    ys240 = '{5, 238, 239, 240, 503};

    #12;
    checkOutput("rst_wren", 32'(wren), 32'd0);
    checkOutput("rst_wraddress", 32'(wraddress), 32'd0);
    checkOutput("rst_wrdata", 32'(wrdata), 32'd0);
    checkOutput("rst_line_done", 32'(line_done), 32'd0);
    checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst_starttrigger", 32'(starttrigger), 32'd0);
    checkOutput("rst_add_line_out", 32'(add_line_out), 32'd0);
    reset = 1'b1;
    modelReset();

    // Before any frame origin nothing may be written.
    applyStimulus(5, 3, 24'h123456);
    applyStimulus(700, 400, 24'h654321);
    applyStimulus(0, 7, 24'h111111);

    // 480p frame with a compressed set of lines.
    line_doubler = 1'b0;
    add_line = 1'b0;
    obsWrites = 0;
    obsLineDone = 0;
    applyStimulus(0, 0, pixelFor(0, 0));
    checkOutput("first_addr", 32'(wraddress), 32'h000);
    runLine(0, 1, 857);
    applyStimulus(0, 1, pixelFor(0, 1));
    checkOutput("line1_first_addr", 32'(wraddress), 32'h400);
    runLine(1, 1, 718);
    applyStimulus(719, 1, pixelFor(719, 1));
    checkOutput("line1_last_addr", 32'(wraddress), 32'h6CF);
    checkOutput("second_line_done", 32'(line_done), 32'd1);
    checkOutput("trig_not_yet", 32'(starttrigger), 32'd0);
    applyStimulus(720, 1, pixelFor(720, 1));
    checkOutput("trig_rise", 32'(starttrigger), 32'd1);
    runLine(1, 721, 857);
    foreach (ys480[i]) runLine(ys480[i], 0, 857);
    checkOutput("writes_480p", 32'(obsWrites), 32'(720 * 8));
    checkOutput("line_done_480p", 32'(obsLineDone), 32'd8);

    // 240p frame: add_line latched at origin, line_doubler flipped mid-frame is ignored.
    line_doubler = 1'b1;
    add_line = 1'b1;
    obsWrites = 0;
    obsLineDone = 0;
    applyStimulus(0, 0, pixelFor(0, 0));
    checkOutput("trig_clear", 32'(starttrigger), 32'd0);
    add_line = 1'b0;
    runLine(0, 1, 4);
    applyStimulus(5, 0, 24'hAB12CD);
    checkOutput("latency_data", 32'(wrdata), 32'hAB12CD);
    checkOutput("latency_addr", 32'(wraddress), 32'h005);
    runLine(0, 6, 700);
    runLine(1, 0, 700);
    line_doubler = 1'b0;
    runLine(2, 0, 700);
    runLine(3, 0, 700);
    applyStimulus(0, 4, pixelFor(0, 4));
    checkOutput("slot_wrap_addr", 32'(wraddress), 32'h000);
    runLine(4, 1, 700);
    foreach (ys240[i]) runLine(ys240[i], 0, 700);
    checkOutput("writes_240p", 32'(obsWrites), 32'(640 * 8));
    checkOutput("line_done_240p", 32'(obsLineDone), 32'd8);
    checkOutput("add_line_held", 32'(add_line_out), 32'd1);

    // Frame origin injected mid-line on line 10.
    for (int y = 0; y < 10; y++) runLine(y, 0, 857);
    runLine(10, 0, 299);
    obsLineDone = 0;
    applyStimulus(0, 0, pixelFor(0, 0));
    checkOutput("restart_frame_start", 32'(frame_start), 32'd1);
    checkOutput("restart_trig", 32'(starttrigger), 32'd0);
    checkOutput("restart_addr", 32'(wraddress), 32'h000);
    runLine(0, 1, 857);
    runLine(1, 0, 857);
    checkOutput("restart_line_done", 32'(obsLineDone), 32'd2);
    runLine(2, 0, 99);
    checkOutput("pre_reset_trig", 32'(starttrigger), 32'd1);

    // Asynchronous reset in the middle of a line.
    reset = 1'b0;
    #1;
    checkOutput("async_wren", 32'(wren), 32'd0);
    checkOutput("async_trig", 32'(starttrigger), 32'd0);
    checkOutput("async_line_done", 32'(line_done), 32'd0);
    checkOutput("async_add_line_out", 32'(add_line_out), 32'd0);
    modelReset();
    #2;
    reset = 1'b1;
    obsWrites = 0;
    runLine(2, 100, 300);
    checkOutput("post_reset_writes", 32'(obsWrites), 32'd0);
    applyStimulus(0, 0, pixelFor(0, 0));
    checkOutput("post_reset_origin", 32'(wren), 32'd1);
    runLine(0, 1, 10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
